// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage: valid/ready handshake, one-entry skid buffer, flush, forwarding tap.
// Define EX_MEM_STALL_CNT_EN to build the MEM back-pressure cycle counter on stall_cnt.
module ex_mem_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned MEM_CTL_W = 2,
  parameter int unsigned WB_CTL_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 valid_e,
  output logic                 ready_e,
  input  logic [MEM_CTL_W-1:0] mem_ctl_e,
  input  logic [WB_CTL_W-1:0]  wb_ctl_e,
  input  logic [DATA_W-1:0]    alu_out_e,
  input  logic [DATA_W-1:0]    write_data_e,
  input  logic [REG_W-1:0]     write_reg_e,
  output logic                 valid_m,
  input  logic                 ready_m,
  output logic [MEM_CTL_W-1:0] mem_ctl_m,
  output logic [WB_CTL_W-1:0]  wb_ctl_m,
  output logic [DATA_W-1:0]    alu_out_m,
  output logic [DATA_W-1:0]    write_data_m,
  output logic [REG_W-1:0]     write_reg_m,
  output logic                 fwd_en,
  output logic [REG_W-1:0]     fwd_reg,
  output logic [DATA_W-1:0]    fwd_data,
  output logic [31:0]          stall_cnt
);

  localparam int unsigned PW = MEM_CTL_W + WB_CTL_W + 2 * DATA_W + REG_W;

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e                state_q;
  logic [PW-1:0]         main_q;
  logic [PW-1:0]         skid_q;
  logic [PW-1:0]         in_pl;
  logic [WB_CTL_W-1:0]   wb_in;
  logic                  in_xfer;
  logic                  out_xfer;

  // A write to r0 is architecturally a no-op, so drop RegWrite before it can forward.
  always_comb begin
    wb_in    = wb_ctl_e;
    wb_in[0] = wb_ctl_e[0] & (write_reg_e != '0);
  end

  assign in_pl    = {mem_ctl_e, wb_in, alu_out_e, write_data_e, write_reg_e};
  assign ready_e  = (state_q != StSkid);
  assign valid_m  = (state_q != StEmpty);
  assign in_xfer  = valid_e & ready_e;
  assign out_xfer = valid_m & ready_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            main_q  <= in_pl;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_pl;
          end else if (out_xfer) begin
            state_q <= StEmpty;
          end else if (in_xfer) begin
            skid_q  <= in_pl;
            state_q <= StSkid;
          end
        end
        StSkid: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= StFull;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign {mem_ctl_m, wb_ctl_m, alu_out_m, write_data_m, write_reg_m} = main_q;

  assign fwd_en   = valid_m & wb_ctl_m[0];
  assign fwd_reg  = write_reg_m;
  assign fwd_data = alu_out_m;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Flush deliberately leaves the count alone; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (valid_m && !ready_m) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline stage with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a register-write forwarding tap. It sits between the execute stage and the data-memory stage. It replaces the fixed-width, always-advancing EX/MEM register with a stage that can stall, can be flushed, and resets cleanly. Payload width, register-index width and control-field widths are parameters.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, width of destination register index
- MEM_CTL_W, 2, width of MEM-stage control field
- WB_CTL_W, 2, width of WB-stage control field; bit 0 is RegWrite

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held and incoming entries
- valid_e  in  1  EX presents an entry
- ready_e  out  1  stage can accept an entry; decoded from state register only
- mem_ctl_e  in  MEM_CTL_W  MEM control
- wb_ctl_e  in  WB_CTL_W  WB control
- alu_out_e  in  DATA_W  ALU result / address
- write_data_e  in  DATA_W  store data
- write_reg_e  in  REG_W  destination register
- valid_m  out  1  entry presented to MEM
- ready_m  in  1  MEM accepts the entry
- mem_ctl_m, wb_ctl_m, alu_out_m, write_data_m, write_reg_m  out  as above  MEM-side payload
- fwd_en  out  1  valid_m & wb_ctl_m[0]
- fwd_reg  out  REG_W  equals write_reg_m
- fwd_data  out  DATA_W  equals alu_out_m
- stall_cnt  out  32  MEM back-pressure cycle count (see Configuration)

## Operation
- In-transfer: valid_e & ready_e. Out-transfer: valid_m & ready_m.
- Storage: main entry (drives the *_m outputs) and skid entry.
- States: EMPTY, FULL, SKID. valid_m = (state != EMPTY). ready_e = (state != SKID).
- EMPTY: on in-transfer, load main and go to FULL.
- FULL:
  - in- and out-transfer: load main with the new entry, stay in FULL.
  - out-transfer only: go to EMPTY.
  - in-transfer only: load skid, go to SKID.
  - neither: hold.
- SKID: on out-transfer, move skid to main and go to FULL. Otherwise hold.
- Write-zero suppression: on any load, if write_reg_e == 0, store wb_ctl_e with bit 0 forced to 0. All other bits are stored unchanged.
- Flush: has priority over all transfers.
  - Next state is EMPTY.
  - An in-transfer in the same cycle is discarded.
  - Payload registers are zeroed.
- Payload registers are not written when no load occurs, so outputs are stable while valid_m=1 and ready_m=0.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, all payload zero, valid_m=0, ready_e=1, fwd_en=0, stall_cnt=0. Release is synchronous to the next clk edge.
- Latency: an entry accepted at edge N is on the *_m outputs after edge N, i.e. in cycle N+1. Throughput is 1 entry per cycle when ready_m=1.
- ready_e depends on registered state only, with no combinational path from ready_m. After ready_m falls, at most one extra entry is absorbed (into the skid) before ready_e falls.
- Ordering is preserved: the skid entry always leaves after the main entry.
- fwd_* outputs are combinational from the main registers, with no added latency.
- Reset mid-operation drops all entries immediately.

## Configuration
- EX_MEM_STALL_CNT_EN defined:
  - stall_cnt increments by 1 every cycle with valid_m=1 and ready_m=0.
  - Wraps at 2^32−1 → 0.
  - Cleared by reset only; flush does not clear it.
- Not defined: stall_cnt is tied to 0 and no counter flop is synthesised.

## Test plan
- Streaming: ready_m=1, valid_e=1 for 4 cycles with alu_out_e=1,2,3,4 → alu_out_m=1,2,3,4 on consecutive cycles, each one cycle after acceptance. ready_e stays 1.
- Back-pressure: in FULL holding A, ready_m=0, present B → B goes to skid, ready_e=0 next cycle. Raise ready_m → A then B out in order, ready_e returns to 1.
- Flush in SKID with valid_e=1 carrying C → next cycle valid_m=0, state EMPTY, payload 0, C never appears.
- write_reg_e=0 with wb_ctl_e=2'b11 → wb_ctl_m=2'b10, fwd_en=0. write_reg_e=7 → wb_ctl_m=2'b11, fwd_en=1, fwd_reg=7.
- Async reset asserted mid-stream between clock edges → outputs zero immediately. First entry after release appears one cycle after its acceptance.
- With EX_MEM_STALL_CNT_EN: hold ready_m=0 for 5 cycles with valid_m=1 → stall_cnt=5. Without the macro → stall_cnt stays 0.
